// File: rtl/sseg_shift_rx_if.sv
// Bundle of the serial display stream inputs and the decoded-frame outputs
// of the 7-segment shift receiver.
interface sseg_shift_rx_if;
  logic        en_i;
  logic        sclk_i;
  logic        sdata_i;
  logic        latch_i;
  logic [63:0] frame_o;
  logic        frame_valid_o;
  logic        frame_err_o;
  logic [6:0]  bit_cnt_o;
  logic [31:0] hex_o;
  logic [7:0]  hex_ok_o;

  modport master (
    output en_i, sclk_i, sdata_i, latch_i,
    input  frame_o, frame_valid_o, frame_err_o, bit_cnt_o, hex_o, hex_ok_o
  );

  modport slave (
    input  en_i, sclk_i, sdata_i, latch_i,
    output frame_o, frame_valid_o, frame_err_o, bit_cnt_o, hex_o, hex_ok_o
  );
endinterface

// File: rtl/sseg_shift_rx.sv
// Oversampling receiver for the 7-segment shift stream: deserialises each
// latched frame into the segment image and decodes every digit back to hex.
module sseg_shift_rx #(
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rstn,
  sseg_shift_rx_if.slave bus
);
  localparam logic [6:0] CNT_FULL = 7'(FRAME_BITS);
  localparam logic [6:0] CNT_SAT  = 7'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] sclk_p0, sdata_p0, latch_p0;
  logic                   sclk_p1, latch_p1;
  logic                   sclk_rise, latch_rise, sdata_s;
  logic [63:0]            shift_p1, shift_nxt;
  logic [6:0]             cnt_p1, cnt_nxt;
  logic [31:0]            hex_nxt;
  logic [7:0]             ok_nxt;

  // Active-low glyph match on bits 6:0; dp is don't-care. Returns {ok, nibble}.
  function automatic logic [4:0] seg_decode(input logic [7:0] seg);
    logic [4:0] r;
    case (seg[6:0])
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Stage p0: identical synchroniser chains keep sdata aligned with sclk
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_p0  <= '0;
      sdata_p0 <= '0;
      latch_p0 <= '0;
      sclk_p1  <= 1'b0;
      latch_p1 <= 1'b0;
    end else begin
      sclk_p0[0]  <= bus.sclk_i;
      sdata_p0[0] <= bus.sdata_i;
      latch_p0[0] <= bus.latch_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_p0[i]  <= sclk_p0[i-1];
        sdata_p0[i] <= sdata_p0[i-1];
        latch_p0[i] <= latch_p0[i-1];
      end
      sclk_p1  <= sclk_p0[SYNC_STAGES-1];
      latch_p1 <= latch_p0[SYNC_STAGES-1];
    end
  end

  // Delay flops run even while disabled so an edge already in flight is not new
  assign sclk_rise  = bus.en_i & sclk_p0[SYNC_STAGES-1] & ~sclk_p1;
  assign latch_rise = bus.en_i & latch_p0[SYNC_STAGES-1] & ~latch_p1;
  assign sdata_s    = sdata_p0[SYNC_STAGES-1];

  // A coincident sclk rise is shifted and counted before the latch check
  always_comb begin
    shift_nxt = sclk_rise ? {shift_p1[62:0], sdata_s} : shift_p1;
    cnt_nxt   = (sclk_rise && cnt_p1 != CNT_SAT) ? cnt_p1 + 7'd1 : cnt_p1;
    hex_nxt   = '0;
    ok_nxt    = '0;
    for (int k = 0; k < 8; k++) begin
      {ok_nxt[k], hex_nxt[4*k +: 4]} = seg_decode(shift_nxt[8*k +: 8]);
    end
  end

  // Stage p1: shift register, bit count and frame outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_p1          <= '0;
      cnt_p1            <= '0;
      bus.frame_o       <= '0;
      bus.hex_o         <= '0;
      bus.hex_ok_o      <= '0;
      bus.frame_valid_o <= 1'b0;
      bus.frame_err_o   <= 1'b0;
    end else begin
      bus.frame_valid_o <= 1'b0;
      bus.frame_err_o   <= 1'b0;
      shift_p1          <= shift_nxt;
      if (!bus.en_i) begin
        cnt_p1 <= '0;
      end else if (latch_rise) begin
        cnt_p1 <= '0;
        if (cnt_nxt == CNT_FULL) begin
          bus.frame_o       <= shift_nxt;
          bus.hex_o         <= hex_nxt;
          bus.hex_ok_o      <= ok_nxt;
          bus.frame_valid_o <= 1'b1;
        end else begin
          bus.frame_err_o <= 1'b1;
        end
      end else begin
        cnt_p1 <= cnt_nxt;
      end
    end
  end

  assign bus.bit_cnt_o = cnt_p1;
endmodule

// File: tb/tb_sseg_shift_rx.sv
// Directed bench for sseg_shift_rx: good, short, long, non-glyph, coincident,
// mid-frame reset and enable-gated frames against hand-computed results.
module tb_sseg_shift_rx;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   passed = 0;
  int   total  = 0;
  int   valid_seen = 0;
  int   err_seen   = 0;

  localparam logic [63:0] GOOD  = 64'hC0F9A4B0999282F8;
  localparam logic [63:0] GLYPH = 64'hC0C0C0C0C0C040FF;

  sseg_shift_rx_if bus ();

  sseg_shift_rx #(.FRAME_BITS(64), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_valid_o === 1'b1) valid_seen++;
    if (bus.frame_err_o === 1'b1) err_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.sdata_i = b;
    repeat (2) @(negedge clk);
    bus.sclk_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.sclk_i = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit((i < 64) ? f[63-i] : 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_latch();
    @(negedge clk);
    bus.latch_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.latch_i = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic test_reset();
    #1;
    chk64("rst_frame", bus.frame_o, 64'h0);
    chk64("rst_hex", {32'h0, bus.hex_o}, 64'h0);
    chk64("rst_hex_ok", {56'h0, bus.hex_ok_o}, 64'h0);
    chk_int("rst_bit_cnt", int'(bus.bit_cnt_o), 0);
    chk_int("rst_valid", int'(bus.frame_valid_o), 0);
    chk_int("rst_err", int'(bus.frame_err_o), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk_int("rst_release_pulses", valid_seen + err_seen, 0);
  endtask

  task automatic test_good_frame();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_bits(GOOD, 64);
    chk_int("good_cnt_before", int'(bus.bit_cnt_o), 64);
    send_latch();
    chk_int("good_valid", valid_seen - v0, 1);
    chk_int("good_err", err_seen - e0, 0);
    chk64("good_frame", bus.frame_o, GOOD);
    chk64("good_hex", {32'h0, bus.hex_o}, 64'h01234567);
    chk64("good_hex_ok", {56'h0, bus.hex_ok_o}, 64'hFF);
    chk_int("good_cnt_after", int'(bus.bit_cnt_o), 0);
  endtask

  task automatic test_short_long();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_bits(64'hFFFF_0000_FFFF_0000, 63);
    chk_int("short_cnt", int'(bus.bit_cnt_o), 63);
    send_latch();
    chk_int("short_err", err_seen - e0, 1);
    chk_int("short_valid", valid_seen - v0, 0);
    chk64("short_frame_hold", bus.frame_o, GOOD);
    send_latch();
    chk_int("zero_bits_err", err_seen - e0, 2);
    send_bits(64'h1234_5678_9ABC_DEF0, 70);
    chk_int("long_cnt_sat", int'(bus.bit_cnt_o), 65);
    send_latch();
    chk_int("long_err", err_seen - e0, 3);
    chk_int("long_valid", valid_seen - v0, 0);
    chk_int("long_cnt_clear", int'(bus.bit_cnt_o), 0);
    chk64("long_frame_hold", bus.frame_o, GOOD);
  endtask

  task automatic test_non_glyph();
    int v0;
    v0 = valid_seen;
    send_bits(GLYPH, 64);
    send_latch();
    chk_int("glyph_valid", valid_seen - v0, 1);
    chk64("glyph_frame", bus.frame_o, GLYPH);
    chk64("glyph_hex_ok", {56'h0, bus.hex_ok_o}, 64'hFE);
    chk64("glyph_hex", {32'h0, bus.hex_o}, 64'h0);
  endtask

  task automatic test_coincident();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    for (int i = 0; i < 63; i++) send_bit(GOOD[63-i]);
    @(negedge clk);
    bus.sdata_i = GOOD[0];
    repeat (2) @(negedge clk);
    bus.sclk_i  = 1'b1;
    bus.latch_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.sclk_i  = 1'b0;
    bus.latch_i = 1'b0;
    repeat (6) @(negedge clk);
    chk_int("coinc_valid", valid_seen - v0, 1);
    chk_int("coinc_err", err_seen - e0, 0);
    chk64("coinc_frame", bus.frame_o, GOOD);
    chk64("coinc_hex", {32'h0, bus.hex_o}, 64'h01234567);
    chk_int("coinc_cnt", int'(bus.bit_cnt_o), 0);
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    send_bits(GOOD, 30);
    chk_int("mid_cnt", int'(bus.bit_cnt_o), 30);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk64("mid_rst_frame", bus.frame_o, 64'h0);
    chk64("mid_rst_hex", {24'h0, bus.hex_ok_o, bus.hex_o}, 64'h0);
    chk_int("mid_rst_cnt", int'(bus.bit_cnt_o), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    v0 = valid_seen; e0 = err_seen;
    repeat (4) @(negedge clk);
    chk_int("mid_release_pulses", (valid_seen - v0) + (err_seen - e0), 0);
    send_bits(GOOD, 64);
    send_latch();
    chk_int("mid_valid", valid_seen - v0, 1);
    chk64("mid_frame", bus.frame_o, GOOD);
    chk64("mid_hex", {32'h0, bus.hex_o}, 64'h01234567);
  endtask

  task automatic test_enable_gating();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    @(negedge clk);
    bus.en_i = 1'b0;
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64);
    chk_int("en_cnt", int'(bus.bit_cnt_o), 0);
    send_latch();
    chk_int("en_pulses", (valid_seen - v0) + (err_seen - e0), 0);
    chk64("en_frame_hold", bus.frame_o, GOOD);
    bus.en_i = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(GLYPH, 64);
    send_latch();
    chk_int("en_back_valid", valid_seen - v0, 1);
    chk64("en_back_frame", bus.frame_o, GLYPH);
  endtask

  initial begin
    bus.en_i    = 1'b1;
    bus.sclk_i  = 1'b0;
    bus.sdata_i = 1'b0;
    bus.latch_i = 1'b0;
    test_reset();
    test_good_frame();
    test_short_long();
    test_non_glyph();
    test_coincident();
    test_reset_mid_frame();
    test_enable_gating();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
